register_file_arbiter: RTL

//   Round-robin controller sharing one 4-entry register file (sel/data_in/data_out/write_enable,

---
 rtl/register_file_arbiter_if.sv | 35 +++
 rtl/register_file_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/register_file_arbiter_if.sv
// Bus bundle between two datapath requesters, the round-robin access controller
// and the shared 4-entry register file.
interface register_file_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  req0;
    logic                  req1;
    logic                  wr0;
    logic                  wr1;
    logic [1:0]            addr0;
    logic [1:0]            addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            gnt;
    logic                  busy;
    logic [1:0]            rf_sel;
    logic [DATA_WIDTH-1:0] rf_data_in;
    logic                  rf_write_enable;
    logic [DATA_WIDTH-1:0] rf_data_out;

    // Controller side
    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, rf_data_out,
        output ack0, ack1, rdata, gnt, busy, rf_sel, rf_data_in, rf_write_enable
    );

    // Requesters plus register file side
    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, rf_data_out,
        input  ack0, ack1, rdata, gnt, busy, rf_sel, rf_data_in, rf_write_enable
    );
endinterface

// File: rtl/register_file_arbiter.sv
// Round-robin sequencer sharing one 4-entry register file between two requesters;
// one access in flight, every output registered.
module register_file_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    register_file_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_DONE,
        R_SETUP,
        R_CAPTURE
    } state_t;

    state_t                state_reg, state_next;
    logic                  ptr_reg, ptr_next;
    logic [1:0]            gnt_reg, gnt_next;
    logic [1:0]            ack_reg, ack_next;
    logic                  busy_reg, busy_next;
    logic                  we_reg, we_next;
    logic [1:0]            sel_reg, sel_next;
    logic [DATA_WIDTH-1:0] din_reg, din_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                  win;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            gnt_reg   <= 2'b00;
            ack_reg   <= 2'b00;
            busy_reg  <= 1'b0;
            we_reg    <= 1'b0;
            sel_reg   <= 2'b00;
            din_reg   <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
            ack_reg   <= ack_next;
            busy_reg  <= busy_next;
            we_reg    <= we_next;
            sel_reg   <= sel_next;
            din_reg   <= din_next;
            rdata_reg <= rdata_next;
        end
    end

    // Outputs are decoded from the next state and registered, so each output
    // is high exactly for the cycle its state is occupied.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        gnt_next   = gnt_reg;
        ack_next   = 2'b00;
        we_next    = 1'b0;
        sel_next   = sel_reg;
        din_next   = din_reg;
        rdata_next = rdata_reg;
        win        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    win      = (bus.req0 && bus.req1) ? ptr_reg : bus.req1;
                    ptr_next = ~win;
                    gnt_next = win ? 2'b10 : 2'b01;
                    sel_next = win ? bus.addr1 : bus.addr0;
                    din_next = win ? bus.wdata1 : bus.wdata0;
                    if (win ? bus.wr1 : bus.wr0) begin
                        state_next = W_SETUP;
                    end else begin
                        state_next = R_SETUP;
                    end
                end
            end
            W_SETUP: begin
                state_next = W_PULSE;
                we_next    = 1'b1;
            end
            W_PULSE: begin
                // Dropping write_enable here is what commits the write.
                state_next = W_DONE;
                ack_next   = gnt_reg;
            end
            W_DONE: begin
                state_next = IDLE;
                gnt_next   = 2'b00;
            end
            R_SETUP: begin
                // Select has been stable a full cycle; read data is settled.
                state_next = R_CAPTURE;
                rdata_next = bus.rf_data_out;
                ack_next   = gnt_reg;
            end
            R_CAPTURE: begin
                state_next = IDLE;
                gnt_next   = 2'b00;
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 2'b00;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign bus.ack0            = ack_reg[0];
    assign bus.ack1            = ack_reg[1];
    assign bus.gnt             = gnt_reg;
    assign bus.busy            = busy_reg;
    assign bus.rf_write_enable = we_reg;
    assign bus.rf_sel          = sel_reg;
    assign bus.rf_data_in      = din_reg;
    assign bus.rdata           = rdata_reg;

endmodule
